// File: rtl/pe_bs_sched.sv
// Scheduler for the 5-tap barrel-shift PE: sample FIFO, weight bank and window sequencer.
// Optional statistics outputs (win_cnt, stall_cnt) are enabled by defining PE_BS_SCHED_STATS_EN.
module pe_bs_sched #(
    parameter int WIN_LEN    = 20,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [2:0]  cfg_w,
    input  logic        cfg_s,
    output logic        cfg_err,
    output logic [7:0]  pe_in,
    output logic [2:0]  pe_sel,
    output logic [2:0]  pe_w1,
    output logic [2:0]  pe_w2,
    output logic [2:0]  pe_w3,
    output logic [2:0]  pe_w4,
    output logic [2:0]  pe_w5,
    output logic        pe_s1,
    output logic        pe_s2,
    output logic        pe_s3,
    output logic        pe_s4,
    output logic        pe_s5,
    output logic        pe_clr_n,
    output logic        busy,
`ifdef PE_BS_SCHED_STATS_EN
    output logic [15:0] win_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [2:0] SEL_HOLD = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             vld_p0;
    logic [7:0]       head_p0;

    logic [CNT_W-1:0] run_cnt;
    logic             flush_cnt;
    logic [2:0]       tap;
    logic             last_run;
    logic             wr_allowed;

    logic [2:0]       w_r [5];
    logic             s_r [5];

    assign in_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign vld_p0   = (state == S_RUN);
    assign head_p0  = mem[rd_ptr];
    assign last_run = (run_cnt == CNT_W'(WIN_LEN - 1));

    // Sample FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (vld_p0) rd_ptr <= rd_ptr + AW'(1);
            case ({push, vld_p0})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FILL;
            S_FILL:  if (en && (count >= CNT_W'(WIN_LEN))) state_nxt = S_RUN;
            S_RUN:   if (last_run) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_FILL;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == S_RUN) || (state == S_FLUSH);
        done       = (state == S_DONE);
        wr_allowed = (state == S_IDLE) || (state == S_FILL) || (state == S_DONE);
        pe_clr_n   = rst_n && (state != S_DONE);
    end

    // Window sequencing counters restart whenever their state is left
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            flush_cnt <= 1'b0;
            tap       <= '0;
        end else begin
            run_cnt   <= (state == S_RUN)   ? run_cnt + CNT_W'(1) : '0;
            flush_cnt <= (state == S_FLUSH) ? ~flush_cnt : 1'b0;
            if (state == S_RUN) tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
            else                tap <= '0;
        end
    end

    // p0 -> PE boundary: popped head and its tap are presented one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_in  <= '0;
            pe_sel <= SEL_HOLD;
        end else if (vld_p0) begin
            pe_in  <= head_p0;
            pe_sel <= tap;
        end else begin
            pe_in  <= '0;
            pe_sel <= SEL_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                w_r[i] <= '0;
                s_r[i] <= 1'b0;
            end
            cfg_err <= 1'b0;
        end else begin
            if (cfg_we && (cfg_addr <= 3'd4) && wr_allowed) begin
                w_r[cfg_addr] <= cfg_w;
                s_r[cfg_addr] <= cfg_s;
            end
            cfg_err <= cfg_we && ((cfg_addr > 3'd4) || !wr_allowed);
        end
    end

    assign pe_w1 = w_r[0];
    assign pe_w2 = w_r[1];
    assign pe_w3 = w_r[2];
    assign pe_w4 = w_r[3];
    assign pe_w5 = w_r[4];
    assign pe_s1 = s_r[0];
    assign pe_s2 = s_r[1];
    assign pe_s3 = s_r[2];
    assign pe_s4 = s_r[3];
    assign pe_s5 = s_r[4];

`ifdef PE_BS_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == S_DONE)        win_cnt   <= sat_inc(win_cnt);
            if (in_valid && !in_ready)  stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule
